// File: rtl/data_ram.sv
// 32-word read/write data memory that clears itself after reset and then
// serves single-cycle writes and combinational, chip-select-gated reads.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_CLEAR | zeroing memory[clear_count], one word per edge; bus ignored
//   S_IDLE  | ready; accepts writes, drives data_out on selected reads
module data_ram #(
    parameter int WORDS      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chip_select,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ready,
    output logic                  write_ack
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clear_count_q, clear_count_d;
    logic                    ready_q, ready_d;
    logic                    write_ack_q, write_ack_d;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_q [WORDS];

    always_comb begin
        state_d       = state_q;
        clear_count_d = clear_count_q;
        ready_d       = ready_q;
        write_ack_d   = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = address;
        mem_wdata     = data_in;

        if (reset) begin
            state_d       = S_CLEAR;
            clear_count_d = '0;
            ready_d       = 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    mem_we        = 1'b1;
                    mem_addr      = clear_count_q;
                    mem_wdata     = '0;
                    clear_count_d = clear_count_q + 1'b1;
                    if (clear_count_q == LAST_ADDR) begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                    end
                end
                S_IDLE: begin
                    if (chip_select && write_enable) begin
                        mem_we      = 1'b1;
                        write_ack_d = 1'b1;
                    end
                end
                default: begin
                    state_d       = S_CLEAR;
                    clear_count_d = '0;
                    ready_d       = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        clear_count_q <= clear_count_d;
        ready_q       <= ready_d;
        write_ack_q   <= write_ack_d;
    end

    // Storage has no reset; the CLEAR sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign data_out  = (ready_q && chip_select && !write_enable) ? mem_q[address]
                                                                 : {DATA_WIDTH{1'bz}};
    assign ready     = ready_q;
    assign write_ack = write_ack_q;

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: clear latency, table-driven bus accesses with a
// write_ack scoreboard, and reset-during-clear restart.
module tb_data_ram;

    logic        clk;
    logic        reset;
    logic        chip_select;
    logic        write_enable;
    logic [4:0]  address;
    logic [31:0] data_in;
    wire  [31:0] data_out;
    logic        ready;
    logic        write_ack;

    wire  [31:0] z_word;
    assign z_word = {32{1'bz}};

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        cs;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] din;
        logic        exp_z;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[15];
    bit   ack_sb[$];

    data_ram dut (
        .clk          (clk),
        .reset        (reset),
        .chip_select  (chip_select),
        .write_enable (write_enable),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out),
        .ready        (ready),
        .write_ack    (write_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks one clear sequence from a just-released reset; if abort_edge is
    // non-zero, reset is reasserted on that edge and the task returns.
    task automatic run_clear(input int abort_edge);
        for (int e = 1; e <= 32; e++) begin
            if (e == abort_edge) reset = 1'b1;
            if (e == 10) begin
                chip_select = 1'b1; write_enable = 1'b1;
                address = 5'd3; data_in = 32'hFFFF_FFFF;
            end else begin
                chip_select = 1'b1; write_enable = 1'b0;
                address = 5'd7; data_in = 32'h0;
            end
            #2;
            check($sformatf("clear_dout_z e%0d", e), data_out, z_word);
            step();
            if (e == abort_edge) begin
                reset = 1'b0;
                check("abort_ready", {31'b0, ready}, 32'd0);
                check("abort_ack", {31'b0, write_ack}, 32'd0);
                return;
            end
            check($sformatf("clear_ready e%0d", e), {31'b0, ready}, (e == 32) ? 32'd1 : 32'd0);
            check($sformatf("clear_ack e%0d", e), {31'b0, write_ack}, 32'd0);
        end
        chip_select = 1'b0; write_enable = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 5'd5,  32'hDEAD_BEEF, 1'b1, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 5'd5,  32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 5'd4,  32'h0,         1'b0, 32'h0000_0000};
        vecs[3]  = '{1'b0, 1'b1, 5'd5,  32'h1234_5678, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 5'd5,  32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 1'b0, 5'd5,  32'h0,         1'b1, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 5'd31, 32'hAAAA_AAAA, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 5'd0,  32'h5555_5555, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 5'd31, 32'h0,         1'b0, 32'hAAAA_AAAA};
        vecs[9]  = '{1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 32'h5555_5555};
        vecs[10] = '{1'b1, 1'b0, 5'd30, 32'h0,         1'b0, 32'h0000_0000};
        vecs[11] = '{1'b1, 1'b1, 5'd7,  32'hCAFE_F00D, 1'b1, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 5'd7,  32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[13] = '{1'b1, 1'b1, 5'd5,  32'hDEAD_BEEF, 1'b1, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 5'd5,  32'h0,         1'b0, 32'hDEAD_BEEF};

        reset = 1'b1; chip_select = 1'b0; write_enable = 1'b0;
        address = 5'd0; data_in = 32'h0;
        step();
        chip_select = 1'b1; address = 5'd7;
        step();
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_ack", {31'b0, write_ack}, 32'd0);
        #1;
        check("rst_dout_z", data_out, z_word);
        reset = 1'b0;
        run_clear(0);

        for (int i = 0; i < 32; i++) begin
            chip_select = 1'b1; write_enable = 1'b0; address = 5'(i);
            #2;
            check($sformatf("init_read a%0d", i), data_out, 32'h0);
        end
        step();
        check("idle_ack", {31'b0, write_ack}, 32'd0);

        for (int i = 0; i < 15; i++) begin
            chip_select  = vecs[i].cs;
            write_enable = vecs[i].we;
            address      = vecs[i].addr;
            data_in      = vecs[i].din;
            #2;
            check($sformatf("vec%0d_dout", i), data_out,
                  vecs[i].exp_z ? z_word : vecs[i].exp_dout);
            ack_sb.push_back(vecs[i].cs && vecs[i].we);
            step();
            if (ack_sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL vec%0d_ack: scoreboard empty, got %0b expected entry", i, write_ack);
            end else begin
                check($sformatf("vec%0d_ack", i), {31'b0, write_ack}, {31'b0, ack_sb.pop_front()});
            end
        end

        // Reset coinciding with a write request: reset wins.
        reset = 1'b1; chip_select = 1'b1; write_enable = 1'b1;
        address = 5'd9; data_in = 32'h1111_1111;
        step();
        check("rstwr_ack", {31'b0, write_ack}, 32'd0);
        check("rstwr_ready", {31'b0, ready}, 32'd0);
        reset = 1'b0;
        run_clear(15);
        run_clear(0);

        chip_select = 1'b1; write_enable = 1'b0;
        address = 5'd7;  #2; check("post_rst_a7", data_out, 32'h0);
        address = 5'd5;  #2; check("post_rst_a5", data_out, 32'h0);
        address = 5'd31; #2; check("post_rst_a31", data_out, 32'h0);
        address = 5'd9;  #2; check("post_rst_a9", data_out, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_ram.md
# data_ram

Read/write 32-word data memory: the writable counterpart to the program ROM, sharing its read-side interface (`address`, `chip_select`, `data_out`). After reset it self-initialises every word to zero, then accepts single-cycle writes and serves asynchronous reads. It sits on the CPU data bus beside the ROM and I/O controller, selected by the address decoder's chip select.

## Interface

Parameters:
- `WORDS`, 32, number of memory words
- `ADDR_WIDTH`, 5, address width; must satisfy 2^ADDR_WIDTH == WORDS
- `DATA_WIDTH`, 32, word width

Ports:
- `clk`  input  1  single clock; all state changes on rising edge
- `reset`  input  1  synchronous, active-high reset
- `chip_select`  input  1  block selected for read or write
- `write_enable`  input  1  1 = write cycle, 0 = read cycle (qualified by `chip_select`)
- `address`  input  ADDR_WIDTH  word address
- `data_in`  input  DATA_WIDTH  write data
- `data_out`  output  DATA_WIDTH  read data; high-impedance when not driving
- `ready`  output  1  initialisation complete; memory accepts accesses
- `write_ack`  output  1  one-cycle pulse acknowledging a completed write

## Operation

- Two states: CLEAR and IDLE, plus a clear counter `clear_count` (ADDR_WIDTH bits).
- Reset (edge with `reset`=1): state <= CLEAR, `clear_count` <= 0, `ready` <= 0, `write_ack` <= 0. Memory contents are not touched on that edge.
- CLEAR: each edge with `reset`=0 writes 0 to `memory[clear_count]` and increments `clear_count`. On the edge that clears word WORDS-1, state <= IDLE and `ready` <= 1; counter wraps to 0.
- CLEAR ignores all `chip_select`/`write_enable` activity: no memory write, no `write_ack`, `data_out` = Z.
- IDLE, write: on an edge with `chip_select`=1 and `write_enable`=1, `memory[address]` <= `data_in`, `write_ack` <= 1. Otherwise `write_ack` <= 0.
- IDLE, read: `data_out` = `memory[address]` combinationally whenever `ready`=1, `chip_select`=1 and `write_enable`=0; follows `address` changes with no clock.
- `data_out` = Z whenever `chip_select`=0, `write_enable`=1, or `ready`=0.
- `chip_select`=0 with `write_enable`=1: no write, no ack.
- Reset asserted in any state, including mid-CLEAR or while writing, overrides everything; the clear sequence restarts from word 0. All previously written data is lost once CLEAR completes.

## Timing

- Reset values: `ready`=0, `write_ack`=0, `data_out`=Z.
- Initialisation latency: `ready` rises after exactly WORDS (32) rising edges with `reset`=0 following the last reset edge.
- Write latency: data is stored on the request edge. `write_ack` is high during the cycle after that edge, for exactly one cycle per write.
- Back-to-back writes on consecutive edges are all accepted. `write_ack` stays high continuously and each write is acknowledged in the following cycle.
- Read-after-write to the same address: the first read cycle after the write edge returns the new data. Before the edge, the old value is in memory, but `data_out` is Z during the write cycle itself.
- Address arithmetic is modulo WORDS. No out-of-range address exists at the default parameters.

## Test plan

- Reset for 2 cycles, release; count edges -> `ready`=0 for edges 1–31, `ready`=1 after edge 32; then read addresses 0..31 -> all 0x00000000.
- After `ready`, write 0xDEADBEEF to address 5 -> `write_ack`=1 for exactly one cycle; read address 5 -> 0xDEADBEEF; read address 4 -> 0x00000000.
- `chip_select`=0, `write_enable`=1, `data_in`=0x12345678, address 5 -> `data_out`=Z, no ack, address 5 still reads 0xDEADBEEF; `chip_select`=1 with `write_enable`=1 -> `data_out`=Z.
- Attempt to write 0xFFFFFFFF to address 3 at edge 10 of CLEAR -> no ack, `data_out`=Z; after `ready`, address 3 reads 0x00000000.
- Back-to-back writes of 0xAAAAAAAA to address 31 and 0x55555555 to address 0 -> `write_ack` high for 2 consecutive cycles; reads return each value and address 30 reads 0.
- Write 0xCAFEF00D to address 7, then assert reset at edge 15 of a new CLEAR -> clear restarts; `ready` rises 32 edges after release; address 7 reads 0x00000000.
